// File: rtl/axi_mem_pkg.sv
// Shared types, response codes and the pmem backing-store functions for axi_lite_mem_slave.
// pmem_read/pmem_write stand in for the simulator's DPI-C memory; the call counters
// and last-write record let a bench observe exactly which accesses reached memory.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_RUN  = 2'd1,
        R_DONE = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RUN  = 2'd1,
        W_DONE = 2'd2
    } w_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [7:0] lat_t;

    // Sparse word-addressed store; unwritten words read as zero.
    logic [31:0] pmem_mem [logic [31:0]];
    int unsigned pmem_rd_calls;
    int unsigned pmem_wr_calls;
    logic [31:0] pmem_last_waddr;
    logic [7:0]  pmem_last_wmask;

    // Backdoor read of the word containing addr (not counted as an access).
    function automatic logic [31:0] pmem_peek(input logic [31:0] addr);
        logic [31:0] key;
        key = addr & 32'hFFFF_FFFC;
        return pmem_mem.exists(key) ? pmem_mem[key] : 32'h0;
    endfunction

    // Backdoor byte-masked write of the word containing addr (not counted as an access).
    function automatic void pmem_poke(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] mask);
        logic [31:0] key;
        logic [31:0] word;
        key  = addr & 32'hFFFF_FFFC;
        word = pmem_mem.exists(key) ? pmem_mem[key] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) word[8*b +: 8] = data[8*b +: 8];
        end
        pmem_mem[key] = word;
    endfunction

    // Memory read access as issued by the slave.
    function automatic logic [31:0] pmem_read(input logic [31:0] addr);
        pmem_rd_calls = pmem_rd_calls + 1;
        return pmem_peek(addr);
    endfunction

    // Memory write access as issued by the slave; wmask bit i enables byte i.
    function automatic void pmem_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [7:0] wmask);
        pmem_wr_calls   = pmem_wr_calls + 1;
        pmem_last_waddr = addr;
        pmem_last_wmask = wmask;
        pmem_poke(addr, data, wmask[3:0]);
    endfunction

endpackage

// File: rtl/axi_mem_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'h01, advancing every cycle.
// Used only when AXI_MEM_RAND_LAT_EN is defined.
module axi_mem_lfsr
    import axi_mem_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    output lat_t data_o
);

    lat_t lfsr_q;
    logic fb_c;

    assign fb_c   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign data_o = lfsr_q;

    // Shift in the feedback bit every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= 8'h01;
        else         lfsr_q <= {lfsr_q[6:0], fb_c};
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave memory model with independent read/write latency engines.
// Optional macro AXI_MEM_RAND_LAT_EN: latency = MIN_LAT + masked LFSR value,
// otherwise latency is FIXED_LAT.
module axi_lite_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000,
    parameter int unsigned FIXED_LAT  = 2,
    parameter int unsigned MIN_LAT    = 0,
    parameter int unsigned LAT_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i
);

    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned NWORDS = DATA_WIDTH / 32;
    localparam int unsigned ADDR_X = ADDR_WIDTH + 1;
    localparam logic [ADDR_X-1:0] BASE_X = ADDR_X'(MEM_BASE);
    localparam logic [ADDR_X-1:0] END_X  = BASE_X + ADDR_X'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    // Reject illegal configurations at elaboration.
    if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64)) || (MIN_LAT + (1 << LAT_W) - 1 > 255)) begin : g_bad_cfg
        $error("axi_lite_mem_slave: illegal DATA_WIDTH or latency configuration");
    end

    // Window check one bit wider than the address so the top of the window cannot wrap.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= BASE_X) && ({1'b0, a} < END_X);
    endfunction

    lat_t lat_c;

`ifdef AXI_MEM_RAND_LAT_EN
    lat_t lfsr_val;

    axi_mem_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .data_o (lfsr_val)
    );

    assign lat_c = lat_t'(MIN_LAT) + (lfsr_val & lat_t'((1 << LAT_W) - 1));
`else
    assign lat_c = lat_t'(FIXED_LAT);
`endif

    // ---------------------------------------------------------------- read engine
    r_state_e              r_state_q, r_state_n;
    lat_t                  r_cnt_q, r_cnt_n;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_n;
    logic                  r_inr_q, r_inr_n;
    logic                  arready_q, rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_fire_c, r_do_c;

    assign ar_fire_c = arvalid_i && arready_q;

    // Read next-state: capture on AR, count down, then hold the response until R handshake.
    always_comb begin
        r_state_n = r_state_q;
        r_cnt_n   = r_cnt_q;
        r_addr_n  = r_addr_q;
        r_inr_n   = r_inr_q;
        r_do_c    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_fire_c) begin
                    r_addr_n  = araddr_i & ALIGN_MASK;
                    r_inr_n   = in_range(araddr_i);
                    r_cnt_n   = lat_c;
                    r_state_n = R_RUN;
                end
            end
            R_RUN: begin
                if (r_cnt_q == '0) begin
                    r_do_c    = 1'b1;
                    r_state_n = R_DONE;
                end else begin
                    r_cnt_n = r_cnt_q - lat_t'(1);
                end
            end
            R_DONE: begin
                if (rready_i) r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // Read state register and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            r_inr_q   <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_n;
            r_cnt_q   <= r_cnt_n;
            r_addr_q  <= r_addr_n;
            r_inr_q   <= r_inr_n;
            arready_q <= (r_state_n == R_IDLE);
            rvalid_q  <= (r_state_n == R_DONE);
        end
    end

    // --------------------------------------------------------------- write engine
    w_state_e              w_state_q, w_state_n;
    lat_t                  w_cnt_q, w_cnt_n;
    logic                  aw_got_q, aw_got_n;
    logic                  w_got_q, w_got_n;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_n;
    logic                  w_inr_q, w_inr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_n;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_fire_c, w_fire_c, w_do_c;

    assign aw_fire_c = awvalid_i && awready_q;
    assign w_fire_c  = wvalid_i && wready_q;

    // Write next-state: gather AW and W in any order, count down, then hold B until handshake.
    always_comb begin
        w_state_n = w_state_q;
        w_cnt_n   = w_cnt_q;
        aw_got_n  = aw_got_q;
        w_got_n   = w_got_q;
        w_addr_n  = w_addr_q;
        w_inr_n   = w_inr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        w_do_c    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_fire_c) begin
                    aw_got_n = 1'b1;
                    w_addr_n = awaddr_i & ALIGN_MASK;
                    w_inr_n  = in_range(awaddr_i);
                end
                if (w_fire_c) begin
                    w_got_n = 1'b1;
                    wdata_n = wdata_i;
                    wstrb_n = wstrb_i;
                end
                if ((aw_got_q || aw_fire_c) && (w_got_q || w_fire_c)) begin
                    w_cnt_n   = lat_c;
                    w_state_n = W_RUN;
                end
            end
            W_RUN: begin
                if (w_cnt_q == '0) begin
                    w_do_c    = 1'b1;
                    w_state_n = W_DONE;
                end else begin
                    w_cnt_n = w_cnt_q - lat_t'(1);
                end
            end
            W_DONE: begin
                if (bready_i) begin
                    aw_got_n  = 1'b0;
                    w_got_n   = 1'b0;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Write state register and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            w_addr_q  <= '0;
            w_inr_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_n;
            w_cnt_q   <= w_cnt_n;
            aw_got_q  <= aw_got_n;
            w_got_q   <= w_got_n;
            w_addr_q  <= w_addr_n;
            w_inr_q   <= w_inr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= (w_state_n == W_IDLE) && !aw_got_n;
            wready_q  <= (w_state_n == W_IDLE) && !w_got_n;
            bvalid_q  <= (w_state_n == W_DONE);
        end
    end

    // ---------------------------------------------------------------- memory port
    // Single process so a same-cycle write always reaches memory before the read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            bresp_q <= RESP_OKAY;
        end else begin
            if (w_do_c) begin
                if (w_inr_q) begin
                    for (int k = 0; k < NWORDS; k++) begin
                        if (wstrb_q[4*k +: 4] != 4'b0000) begin
                            pmem_write(32'(w_addr_q) + 32'(4 * k), wdata_q[32*k +: 32],
                                       {4'b0000, wstrb_q[4*k +: 4]});
                        end
                    end
                    bresp_q <= RESP_OKAY;
                end else begin
                    bresp_q <= RESP_SLVERR;
                end
            end
            if (r_do_c) begin
                if (r_inr_q) begin
                    for (int k = 0; k < NWORDS; k++) begin
                        rdata_q[32*k +: 32] <= pmem_read(32'(r_addr_q) + 32'(4 * k));
                    end
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
            end
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave (default build: fixed latency 2).
// Expected read/write responses are queued at issue time and checked on completion.
module tb_axi_lite_mem_slave;
    import axi_mem_pkg::*;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic [31:0] araddr6 = '0, awaddr6 = '0;
    logic [63:0] wdata6 = '0;
    logic [7:0]  wstrb6 = '0;
    logic        arvalid6 = 1'b0, rready6 = 1'b0, awvalid6 = 1'b0, wvalid6 = 1'b0, bready6 = 1'b0;
    logic        arready6, rvalid6, awready6, wready6, bvalid6;
    logic [63:0] rdata6;
    logic [1:0]  rresp6, bresp6;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [33:0] rq[$];  // {data, resp}
    logic [1:0]  bq[$];

    axi_lite_mem_slave u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
    );

    axi_lite_mem_slave #(.DATA_WIDTH(64)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .araddr_i(araddr6), .arvalid_i(arvalid6), .arready_o(arready6),
        .rdata_o(rdata6), .rresp_o(rresp6), .rvalid_o(rvalid6), .rready_i(rready6),
        .awaddr_i(awaddr6), .awvalid_i(awvalid6), .awready_o(awready6),
        .wdata_i(wdata6), .wstrb_i(wstrb6), .wvalid_i(wvalid6), .wready_o(wready6),
        .bresp_o(bresp6), .bvalid_o(bvalid6), .bready_i(bready6)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present AR, wait for acceptance, return the fire cycle.
    task automatic ar_issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                            output int c0);
        int g = 0;
        araddr = a;
        arvalid = 1'b1;
        rq.push_back({d, r});
        while (arready !== 1'b1 && g < 20) begin tick(); g++; end
        tests_run++;
        if (arready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ar_accept: arready=%b required 1", arready);
        end
        c0 = cyc;
        tick();
        arvalid = 1'b0;
    endtask

    // Wait for R, check latency and payload against the queue head, then handshake.
    task automatic r_collect(input string nm, input int c0);
        int g = 0;
        logic [33:0] e;
        while (rvalid !== 1'b1 && g < 64) begin tick(); g++; end
        e = rq.pop_front();
        tests_run++;
        if (rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_rvalid_timeout: rvalid=%b required 1", nm, rvalid);
            return;
        end
        tests_run++;
        if (cyc - c0 != L + 2) begin
            tests_failed++;
            $display("FAIL %s_rlat: rvalid in cycle %0d required %0d", nm, cyc - c0, L + 2);
        end
        tests_run++;
        if (rdata !== e[33:2] || rresp !== e[1:0]) begin
            tests_failed++;
            $display("FAIL %s_rdata: got %h/%b required %h/%b", nm, rdata, rresp, e[33:2], e[1:0]);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // W first, AW w_lead cycles later (0 = same cycle); returns the cycle of the last fire.
    task automatic w_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] r, input int w_lead, output int c0);
        bq.push_back(r);
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        if (w_lead > 0) begin
            tests_run++;
            if (wready !== 1'b1) begin
                tests_failed++;
                $display("FAIL w_accept: wready=%b required 1", wready);
            end
            tick();
            wvalid = 1'b0;
            tests_run++;
            if (wready !== 1'b0 || awready !== 1'b1) begin
                tests_failed++;
                $display("FAIL w_held: wready=%b awready=%b required 0/1", wready, awready);
            end
            repeat (w_lead - 1) tick();
        end
        awaddr = a;
        awvalid = 1'b1;
        tests_run++;
        if (awready !== 1'b1 || (w_lead == 0 && wready !== 1'b1)) begin
            tests_failed++;
            $display("FAIL aw_accept: awready=%b wready=%b required 1/1", awready, wready);
        end
        c0 = cyc;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
    endtask

    task automatic b_collect(input string nm, input int c0);
        int g = 0;
        logic [1:0] e;
        while (bvalid !== 1'b1 && g < 64) begin tick(); g++; end
        e = bq.pop_front();
        tests_run++;
        if (bvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_bvalid_timeout: bvalid=%b required 1", nm, bvalid);
            return;
        end
        tests_run++;
        if (cyc - c0 != L + 2 || bresp !== e) begin
            tests_failed++;
            $display("FAIL %s_b: cycle %0d resp %b required %0d/%b", nm, cyc - c0, bresp, L + 2, e);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests_run++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100 || rdata !== 32'h0 ||
            rresp !== 2'b00 || bresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_in: rdy=%b%b%b vld=%b%b rdata=%h rresp=%b bresp=%b required 111 00 0 00 00",
                     arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        tests_run++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100 || rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_out: rdy=%b%b%b vld=%b%b rdata=%h required 111 00 0",
                     arready, awready, wready, rvalid, bvalid, rdata);
        end
    endtask

    task automatic test_read_basic();
        int c0;
        int unsigned n0;
        pmem_poke(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        n0 = pmem_rd_calls;
        ar_issue(32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY, c0);
        r_collect("read_basic", c0);
        tests_run++;
        if (pmem_rd_calls - n0 != 1) begin
            tests_failed++;
            $display("FAIL read_calls: %0d calls required 1", pmem_rd_calls - n0);
        end
        // Unaligned address within the word reads the aligned word.
        ar_issue(32'h8000_0013, 32'hDEAD_BEEF, RESP_OKAY, c0);
        r_collect("read_unaligned", c0);
    endtask

    task automatic test_write_split();
        int c0;
        int unsigned n0;
        pmem_poke(32'h8000_0020, 32'hAABB_CCDD, 4'hF);
        n0 = pmem_wr_calls;
        w_issue(32'h8000_0020, 32'h1122_3344, 4'b0011, RESP_OKAY, 3, c0);
        b_collect("write_split", c0);
        tests_run++;
        if (pmem_wr_calls - n0 != 1 || pmem_last_wmask !== 8'h03 || pmem_last_waddr !== 32'h8000_0020) begin
            tests_failed++;
            $display("FAIL write_call: n=%0d mask=%h addr=%h required 1/03/80000020",
                     pmem_wr_calls - n0, pmem_last_wmask, pmem_last_waddr);
        end
        tests_run++;
        if (pmem_peek(32'h8000_0020) !== 32'hAABB_3344) begin
            tests_failed++;
            $display("FAIL write_merge: mem=%h required aabb3344", pmem_peek(32'h8000_0020));
        end
        ar_issue(32'h8000_0020, 32'hAABB_3344, RESP_OKAY, c0);
        r_collect("write_readback", c0);
        // Same-cycle AW and W.
        w_issue(32'h8000_0024, 32'h5566_7788, 4'hF, RESP_OKAY, 0, c0);
        b_collect("write_same", c0);
        ar_issue(32'h8000_0024, 32'h5566_7788, RESP_OKAY, c0);
        r_collect("write_same_rb", c0);
    endtask

    task automatic test_range();
        int c0;
        int unsigned nr, nw;
        pmem_poke(32'h87FF_FFFC, 32'h0BAD_F00D, 4'hF);
        nr = pmem_rd_calls;
        ar_issue(32'h0000_1000, 32'h0, RESP_SLVERR, c0);
        r_collect("oob_low", c0);
        tests_run++;
        if (pmem_rd_calls != nr) begin
            tests_failed++;
            $display("FAIL oob_read_call: %0d calls required 0", pmem_rd_calls - nr);
        end
        ar_issue(32'h7FFF_FFFC, 32'h0, RESP_SLVERR, c0);
        r_collect("below_base", c0);
        ar_issue(32'h87FF_FFFC, 32'h0BAD_F00D, RESP_OKAY, c0);
        r_collect("top_word", c0);
        ar_issue(32'h8800_0000, 32'h0, RESP_SLVERR, c0);
        r_collect("past_top", c0);
        ar_issue(32'hFFFF_FFFC, 32'h0, RESP_SLVERR, c0);
        r_collect("addr_max", c0);
        nw = pmem_wr_calls;
        w_issue(32'h8800_0000, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 0, c0);
        b_collect("oob_write", c0);
        tests_run++;
        if (pmem_wr_calls != nw || pmem_peek(32'h8800_0000) !== 32'h0) begin
            tests_failed++;
            $display("FAIL oob_write_mem: calls=%0d mem=%h required 0/00000000",
                     pmem_wr_calls - nw, pmem_peek(32'h8800_0000));
        end
    endtask

    task automatic test_overlap();
        int c0;
        int g = 0;
        logic [33:0] er;
        logic [1:0]  eb;
        pmem_poke(32'h8000_0040, 32'hCAFE_F00D, 4'hF);
        rq.push_back({32'hCAFE_F00D, RESP_OKAY});
        bq.push_back(RESP_OKAY);
        araddr = 32'h8000_0040; arvalid = 1'b1;
        awaddr = 32'h8000_0050; awvalid = 1'b1;
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        tests_run++;
        if ({arready, awready, wready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL overlap_accept: rdy=%b required 111", {arready, awready, wready});
        end
        c0 = cyc;
        tick();
        {arvalid, awvalid, wvalid} = 3'b000;
        while (rvalid !== 1'b1 && g < 64) begin tick(); g++; end
        er = rq.pop_front();
        eb = bq.pop_front();
        tests_run++;
        if (cyc - c0 != L + 2 || rvalid !== 1'b1 || bvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL overlap_timing: cycle %0d rvalid=%b bvalid=%b required %0d/1/1",
                     cyc - c0, rvalid, bvalid, L + 2);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (rvalid !== 1'b1 || bvalid !== 1'b1 || {rdata, rresp} !== er || bresp !== eb) begin
                tests_failed++;
                $display("FAIL overlap_hold%0d: v=%b%b rdata=%h bresp=%b required 11/%h/%b",
                         i, rvalid, bvalid, rdata, bresp, er[33:2], eb);
            end
            tick();
        end
        {rready, bready} = 2'b11;
        tick();
        {rready, bready} = 2'b00;
        tests_run++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || pmem_peek(32'h8000_0050) !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL overlap_release: v=%b%b mem=%h required 00/12345678",
                     rvalid, bvalid, pmem_peek(32'h8000_0050));
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        pmem_poke(32'h8000_0060, 32'h0000_0060, 4'hF);
        pmem_poke(32'h8000_0064, 32'h0000_0064, 4'hF);
        ar_issue(32'h8000_0060, 32'h0000_0060, RESP_OKAY, c0);
        r_collect("b2b_first", c0);
        tests_run++;
        if (arready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_arready: arready=%b required 1", arready);
        end
        ar_issue(32'h8000_0064, 32'h0000_0064, RESP_OKAY, c0);
        r_collect("b2b_second", c0);
    endtask

    task automatic test_reset_mid();
        int c0;
        int unsigned n0;
        n0 = pmem_rd_calls;
        ar_issue(32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY, c0);
        void'(rq.pop_back());
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_out: rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        tests_run++;
        if (pmem_rd_calls != n0 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_drop: calls=%0d rvalid=%b required 0/0", pmem_rd_calls - n0, rvalid);
        end
        ar_issue(32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY, c0);
        r_collect("after_reset", c0);
    endtask

    task automatic test_wide64();
        int g = 0;
        int c0;
        int unsigned n0;
        pmem_poke(32'h8000_0008, 32'h5555_5555, 4'hF);
        pmem_poke(32'h8000_000C, 32'hAAAA_AAAA, 4'hF);
        n0 = pmem_wr_calls;
        awaddr6 = 32'h8000_0008; awvalid6 = 1'b1;
        wdata6 = 64'h0123_4567_89AB_CDEF; wstrb6 = 8'hF0; wvalid6 = 1'b1;
        c0 = cyc;
        tick();
        {awvalid6, wvalid6} = 2'b00;
        while (bvalid6 !== 1'b1 && g < 64) begin tick(); g++; end
        tests_run++;
        if (bvalid6 !== 1'b1 || cyc - c0 != L + 2 || bresp6 !== RESP_OKAY) begin
            tests_failed++;
            $display("FAIL w64_b: bvalid=%b cycle %0d bresp=%b required 1/%0d/00", bvalid6, cyc - c0, bresp6, L + 2);
        end
        tests_run++;
        if (pmem_wr_calls - n0 != 1 || pmem_last_waddr !== 32'h8000_000C || pmem_last_wmask !== 8'h0F) begin
            tests_failed++;
            $display("FAIL w64_call: n=%0d addr=%h mask=%h required 1/8000000c/0f",
                     pmem_wr_calls - n0, pmem_last_waddr, pmem_last_wmask);
        end
        bready6 = 1'b1;
        tick();
        bready6 = 1'b0;
        araddr6 = 32'h8000_000C; arvalid6 = 1'b1;
        c0 = cyc;
        tick();
        arvalid6 = 1'b0;
        g = 0;
        while (rvalid6 !== 1'b1 && g < 64) begin tick(); g++; end
        tests_run++;
        if (rvalid6 !== 1'b1 || rdata6 !== 64'h0123_4567_5555_5555 || rresp6 !== RESP_OKAY) begin
            tests_failed++;
            $display("FAIL r64_data: rvalid=%b rdata=%h rresp=%b required 1/0123456755555555/00",
                     rvalid6, rdata6, rresp6);
        end
        rready6 = 1'b1;
        tick();
        rready6 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_split();
        test_range();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        test_wide64();
        tests_run++;
        if (rq.size() != 0 || bq.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d reads %0d writes outstanding required 0/0", rq.size(), bq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
